// File: rtl/orv64_clk_gate_ctrl_if.sv
// Bundle between the core top and the per-domain clock-gating controller.
// The master side is the core top, which drives configuration and domain activity.
// The slave side is the controller, which returns the gating enables and status.
interface orv64_clk_gate_ctrl_if #(
  parameter int NUM_DOM = 4,
  parameter int THR_W   = 8
);
  logic               cfg_gate_en;
  logic [THR_W-1:0]   cfg_idle_thr;
  logic [NUM_DOM-1:0] dom_busy;
  logic [NUM_DOM-1:0] dom_wake;
  logic [NUM_DOM-1:0] dom_force_on;
  logic [NUM_DOM-1:0] clk_en;
  logic [NUM_DOM-1:0] dom_rdy;
  logic [NUM_DOM-1:0] dom_gated;

  modport master (
    output cfg_gate_en, cfg_idle_thr, dom_busy, dom_wake, dom_force_on,
    input  clk_en, dom_rdy, dom_gated
  );

  modport slave (
    input  cfg_gate_en, cfg_idle_thr, dom_busy, dom_wake, dom_force_on,
    output clk_en, dom_rdy, dom_gated
  );
endinterface

// File: rtl/orv64_clk_gate_ctrl.sv
// Per-domain clock-gating controller for the orv64 core.
// Each domain runs its own FSM. A domain is gated after a programmable run of
// idle cycles. It re-enables on demand and reports ready after a fixed settle
// window.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | domain clocked and ready; counting consecutive idle cycles
//   GATED | clk_en low; waiting for any reason to run again
//   WAKE  | clk_en high, settling for WAKE_CYCLES before dom_rdy rises
module orv64_clk_gate_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int THR_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  orv64_clk_gate_ctrl_if.slave  bus
);

  // Wide enough to count from 0 up to WAKE_CYCLES-1; never narrower than 1 bit.
  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    state_t           state_q, state_d;
    logic [THR_W-1:0] idle_q, idle_d;
    logic [WCW-1:0]   wake_q, wake_d;
    logic             en_q, rdy_q, gated_q;
    logic             idle;

    // A domain counts as idle only when nothing needs it and gating is allowed.
    always_comb begin
      idle = !bus.dom_busy[d] && !bus.dom_wake[d] && !bus.dom_force_on[d] &&
             bus.cfg_gate_en && (bus.cfg_idle_thr != '0);
    end

    // Next-state and counter update. The GATED exit condition is simply !idle.
    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
        ST_RUN: begin
          if (!idle) begin
            idle_d = '0;
          end else if (idle_q == bus.cfg_idle_thr - THR_W'(1)) begin
            state_d = ST_GATED;
            idle_d  = '0;
          end else begin
            // Wraps modulo 2^THR_W if the threshold was lowered below the count.
            idle_d = idle_q + THR_W'(1);
          end
        end
        ST_GATED: begin
          if (!idle) begin
            state_d = ST_WAKE;
            wake_d  = '0;
          end
        end
        ST_WAKE: begin
          // Settle window is fixed; inputs are ignored until it completes.
          wake_d = wake_q + WCW'(1);
          if (wake_q == WCW'(WAKE_CYCLES - 1)) begin
            state_d = ST_RUN;
            wake_d  = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          idle_d  = '0;
          wake_d  = '0;
        end
      endcase
    end

    // State, counters and outputs. The outputs are registered and decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_RUN;
        idle_q  <= '0;
        wake_q  <= '0;
        en_q    <= 1'b1;
        rdy_q   <= 1'b1;
        gated_q <= 1'b0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
        en_q    <= (state_d != ST_GATED);
        rdy_q   <= (state_d == ST_RUN);
        gated_q <= (state_d == ST_GATED);
      end
    end

    assign bus.clk_en[d]    = en_q;
    assign bus.dom_rdy[d]   = rdy_q;
    assign bus.dom_gated[d] = gated_q;
  end

endmodule

// File: tb/tb_orv64_clk_gate_ctrl.sv
// Directed testbench for orv64_clk_gate_ctrl (NUM_DOM=4, THR_W=8, WAKE_CYCLES=2).
module tb_orv64_clk_gate_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  orv64_clk_gate_ctrl_if #(.NUM_DOM(4), .THR_W(8)) bus ();

  orv64_clk_gate_ctrl #(
    .NUM_DOM(4), .THR_W(8), .WAKE_CYCLES(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one edge; inputs change and outputs are sampled 1 unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_gate_en  = 1'b1;
    bus.cfg_idle_thr = 8'd4;
    bus.dom_busy     = 4'h0;
    bus.dom_wake     = 4'h0;
    bus.dom_force_on = 4'h0;
    tick(2);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL reset_clk_en actual=%h expected=F", bus.clk_en); end
    n_checks++;
    if (bus.dom_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_rdy actual=%h expected=F", bus.dom_rdy); end
    n_checks++;
    if (bus.dom_gated !== 4'h0) begin n_fail++; $display("FAIL reset_gated actual=%h expected=0", bus.dom_gated); end
    rst = 1'b0;
    tick(3);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL idle3_clk_en actual=%h expected=F", bus.clk_en); end
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'h0) begin n_fail++; $display("FAIL idle4_clk_en actual=%h expected=0", bus.clk_en); end
    n_checks++;
    if (bus.dom_gated !== 4'hF) begin n_fail++; $display("FAIL idle4_gated actual=%h expected=F", bus.dom_gated); end
    n_checks++;
    if (bus.dom_rdy !== 4'h0) begin n_fail++; $display("FAIL idle4_rdy actual=%h expected=0", bus.dom_rdy); end
  endtask

  task automatic test_wake_pulse();
    bus.dom_wake = 4'b0010;
    tick(1);
    bus.dom_wake = 4'b0000;
    n_checks++;
    if (bus.clk_en !== 4'b0010) begin n_fail++; $display("FAIL wake_clk_en actual=%h expected=2", bus.clk_en); end
    n_checks++;
    if (bus.dom_rdy !== 4'b0000) begin n_fail++; $display("FAIL wake_rdy0 actual=%h expected=0", bus.dom_rdy); end
    n_checks++;
    if (bus.dom_gated !== 4'b1101) begin n_fail++; $display("FAIL wake_gated actual=%h expected=D", bus.dom_gated); end
    tick(1);
    n_checks++;
    if (bus.dom_rdy !== 4'b0000) begin n_fail++; $display("FAIL wake_rdy1 actual=%h expected=0", bus.dom_rdy); end
    tick(1);
    n_checks++;
    if (bus.dom_rdy !== 4'b0010) begin n_fail++; $display("FAIL wake_rdy2 actual=%h expected=2", bus.dom_rdy); end
    // Idle count restarts from 0: 3 idle edges keep the clock, the 4th gates.
    tick(3);
    n_checks++;
    if (bus.clk_en !== 4'b0010) begin n_fail++; $display("FAIL rewake_idle3 actual=%h expected=2", bus.clk_en); end
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'b0000) begin n_fail++; $display("FAIL rewake_idle4 actual=%h expected=0", bus.clk_en); end
  endtask

  task automatic test_busy_boundary();
    bus.cfg_idle_thr = 8'd3;
    bus.dom_busy = 4'b0001;
    tick(3);
    n_checks++;
    if (bus.dom_rdy !== 4'b0001) begin n_fail++; $display("FAIL busy_wake_rdy actual=%h expected=1", bus.dom_rdy); end
    // Busy lands exactly on the edge where the count would expire.
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 3; c++) begin
        bus.dom_busy = (c == 2) ? 4'b0001 : 4'b0000;
        tick(1);
        n_checks++;
        if (bus.clk_en[0] !== 1'b1) begin n_fail++; $display("FAIL busy_period p=%0d c=%0d actual=%b expected=1", p, c, bus.clk_en[0]); end
      end
    end
    // The same with a wake request on the expiring edge.
    bus.dom_busy = 4'b0000;
    tick(2);
    bus.dom_wake = 4'b0001;
    tick(1);
    bus.dom_wake = 4'b0000;
    n_checks++;
    if (bus.clk_en[0] !== 1'b1) begin n_fail++; $display("FAIL wake_on_expiry actual=%b expected=1", bus.clk_en[0]); end
    tick(2);
    n_checks++;
    if (bus.clk_en[0] !== 1'b1) begin n_fail++; $display("FAIL idle2_after actual=%b expected=1", bus.clk_en[0]); end
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'b0000) begin n_fail++; $display("FAIL idle3_after actual=%h expected=0", bus.clk_en); end
  endtask

  task automatic test_gate_disable();
    bus.cfg_gate_en = 1'b0;
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL gdis_clk_en actual=%h expected=F", bus.clk_en); end
    n_checks++;
    if (bus.dom_rdy !== 4'h0) begin n_fail++; $display("FAIL gdis_rdy0 actual=%h expected=0", bus.dom_rdy); end
    tick(1);
    n_checks++;
    if (bus.dom_rdy !== 4'h0) begin n_fail++; $display("FAIL gdis_rdy1 actual=%h expected=0", bus.dom_rdy); end
    tick(1);
    n_checks++;
    if (bus.dom_rdy !== 4'hF) begin n_fail++; $display("FAIL gdis_rdy2 actual=%h expected=F", bus.dom_rdy); end
    for (int i = 0; i < 300; i++) begin
      tick(1);
      n_checks++;
      if (bus.clk_en !== 4'hF || bus.dom_gated !== 4'h0) begin
        n_fail++;
        $display("FAIL gdis_hold cyc=%0d clk_en=%h gated=%h expected F/0", i, bus.clk_en, bus.dom_gated);
      end
    end
  endtask

  task automatic test_force_and_thr0();
    bus.cfg_gate_en  = 1'b1;
    bus.cfg_idle_thr = 8'd1;
    bus.dom_force_on = 4'b0100;
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'b0100) begin n_fail++; $display("FAIL force_clk_en actual=%h expected=4", bus.clk_en); end
    n_checks++;
    if (bus.dom_gated !== 4'b1011) begin n_fail++; $display("FAIL force_gated actual=%h expected=B", bus.dom_gated); end
    tick(10);
    n_checks++;
    if (bus.clk_en !== 4'b0100) begin n_fail++; $display("FAIL force_hold actual=%h expected=4", bus.clk_en); end
    bus.cfg_idle_thr = 8'd0;
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL thr0_clk_en actual=%h expected=F", bus.clk_en); end
    tick(2);
    n_checks++;
    if (bus.dom_rdy !== 4'hF) begin n_fail++; $display("FAIL thr0_rdy actual=%h expected=F", bus.dom_rdy); end
    bus.dom_force_on = 4'b0000;
    tick(20);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL thr0_hold actual=%h expected=F", bus.clk_en); end
  endtask

  task automatic test_async_reset();
    bus.cfg_idle_thr = 8'd1;
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'h0) begin n_fail++; $display("FAIL ar_pre_gated actual=%h expected=0", bus.clk_en); end
    bus.dom_wake = 4'b0001;
    tick(1);
    bus.dom_wake = 4'b0000;
    n_checks++;
    if (bus.clk_en !== 4'b0001 || bus.dom_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL ar_pre_wake clk_en=%h rdy=%h expected 1/0", bus.clk_en, bus.dom_rdy);
    end
    // Domain 0 is in WAKE and the others are GATED; assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.clk_en !== 4'hF || bus.dom_rdy !== 4'hF || bus.dom_gated !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset clk_en=%h rdy=%h gated=%h expected F/F/0", bus.clk_en, bus.dom_rdy, bus.dom_gated);
    end
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_thr_change();
    // The count reaches 5 under thr=8. Lowering thr to 3 then forces a wrap through 255.
    bus.cfg_idle_thr = 8'd8;
    tick(5);
    bus.cfg_idle_thr = 8'd3;
    tick(253);
    n_checks++;
    if (bus.clk_en !== 4'hF) begin n_fail++; $display("FAIL thr_chg_253 actual=%h expected=F", bus.clk_en); end
    tick(1);
    n_checks++;
    if (bus.clk_en !== 4'h0) begin n_fail++; $display("FAIL thr_chg_254 actual=%h expected=0", bus.clk_en); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_wake_pulse();
    test_busy_boundary();
    test_gate_disable();
    test_force_and_thr0();
    test_async_reset();
    test_thr_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
